// File: rtl/seven_seg_mux.sv
// ============================================================================
// Module   : seven_seg_mux
// Purpose  : N-digit multiplexed common-anode 7-segment driver with PWM,
//            leading-zero blanking and frame-synchronous shadow latching.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_WIDTH    = 18,
  parameter int BRIGHT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    blank_lz,
  input  logic [BRIGHT_WIDTH-1:0] brightness,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_MAX  = '1;
  localparam logic [6:0]           SEG_OFF  = 7'h7F;

  logic [DIV_WIDTH-1:0]    div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
  logic [4*NUM_DIGITS-1:0] value_sh_q, value_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic                    blank_lz_sh_q, blank_lz_sh_d;
  logic [BRIGHT_WIDTH-1:0] brightness_sh_q, brightness_sh_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_start_q, frame_start_d;

  logic                    load;
  logic [4*NUM_DIGITS-1:0] src_value;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic                    src_blz;
  logic [BRIGHT_WIDTH-1:0] src_br;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic                    zero_acc;
  logic [3:0]              nib;
  logic                    dp_bit;
  logic                    blanked;
  logic [BRIGHT_WIDTH-1:0] pwm_top;
  logic                    lit;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  always_comb begin
    load = enable && (digit_idx_q == '0) && (div_cnt_q == '0);

    // The load cycle decodes from the live inputs so the frame's first digit is never stale.
    src_value = load ? value      : value_sh_q;
    src_dp    = load ? dp         : dp_sh_q;
    src_blz   = load ? blank_lz   : blank_lz_sh_q;
    src_br    = load ? brightness : brightness_sh_q;

    zero_acc   = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc      = zero_acc && (src_value[4*i +: 4] == 4'h0);
      upper_zero[i] = zero_acc;
    end

    nib     = 4'h0;
    dp_bit  = 1'b0;
    blanked = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_q == IDX_W'(i)) begin
        nib     = src_value[4*i +: 4];
        dp_bit  = src_dp[i];
        blanked = (i != 0) && src_blz && upper_zero[i];
      end
    end

    pwm_top = div_cnt_q[DIV_WIDTH-1 -: BRIGHT_WIDTH];
    lit     = (src_br == '1) || (pwm_top < src_br);

    an_d   = '1;
    seg_d  = SEG_OFF;
    dp_n_d = 1'b1;
    if (enable && lit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (digit_idx_q != IDX_W'(i));
      end
      seg_d  = blanked ? SEG_OFF : glyph(nib);
      dp_n_d = !dp_bit;
    end
    frame_start_d = load;

    div_cnt_d   = '0;
    digit_idx_d = '0;
    if (enable) begin
      div_cnt_d   = div_cnt_q + DIV_ONE;
      digit_idx_d = digit_idx_q;
      if (div_cnt_q == DIV_MAX) begin
        digit_idx_d = (digit_idx_q == LAST_IDX) ? '0 : digit_idx_q + IDX_ONE;
      end
    end

    value_sh_d      = load ? value      : value_sh_q;
    dp_sh_d         = load ? dp         : dp_sh_q;
    blank_lz_sh_d   = load ? blank_lz   : blank_lz_sh_q;
    brightness_sh_d = load ? brightness : brightness_sh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q       <= '0;
      digit_idx_q     <= '0;
      value_sh_q      <= '0;
      dp_sh_q         <= '0;
      blank_lz_sh_q   <= 1'b0;
      brightness_sh_q <= '0;
      seg_q           <= SEG_OFF;
      dp_n_q          <= 1'b1;
      an_q            <= '1;
      frame_start_q   <= 1'b0;
    end else begin
      div_cnt_q       <= div_cnt_d;
      digit_idx_q     <= digit_idx_d;
      value_sh_q      <= value_sh_d;
      dp_sh_q         <= dp_sh_d;
      blank_lz_sh_q   <= blank_lz_sh_d;
      brightness_sh_q <= brightness_sh_d;
      seg_q           <= seg_d;
      dp_n_q          <= dp_n_d;
      an_q            <= an_d;
      frame_start_q   <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_mux.sv
// Bench for seven_seg_mux (3 digits, 16-cycle dwell, 2-bit brightness) against a
// frame-phase reference model plus directed vectors from the digit table.
`default_nettype none

module tb_seven_seg_mux;

  localparam int ND = 3;
  localparam int DW = 4;
  localparam int BW = 2;
  localparam int DWELL = 16;
  localparam int FRAME = ND * DWELL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [11:0]   value;
  logic [2:0]    dp;
  logic          blank_lz;
  logic [1:0]    brightness;
  logic          enable;
  logic [6:0]    seg;
  logic          dp_n;
  logic [2:0]    an;
  logic          frame_start;

  int total = 0;
  int bad   = 0;

  seven_seg_mux #(.NUM_DIGITS(ND), .DIV_WIDTH(DW), .BRIGHT_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .blank_lz(blank_lz),
    .brightness(brightness), .enable(enable), .seg(seg), .dp_n(dp_n),
    .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: a single position-in-frame counter and a latched copy of the inputs.
  int         m_phase;
  logic [11:0] m_val;
  logic [2:0]  m_dp;
  logic        m_blz;
  logic [1:0]  m_br;
  logic [2:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp_n;
  logic        e_fs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_val = '0; m_dp = '0; m_blz = 1'b0; m_br = '0;
    e_an = 3'b111; e_seg = 7'h7F; e_dp_n = 1'b1; e_fs = 1'b0;
  endtask

  task automatic model_step();
    int d, div;
    logic [11:0] upper;
    logic is_lit, is_blank;
    if (!enable) begin
      m_phase = 0;
      e_an = 3'b111; e_seg = 7'h7F; e_dp_n = 1'b1; e_fs = 1'b0;
    end else begin
      if (m_phase == 0) begin
        m_val = value; m_dp = dp; m_blz = blank_lz; m_br = brightness;
      end
      d        = m_phase / DWELL;
      div      = m_phase % DWELL;
      upper    = m_val >> (4 * d);
      is_lit   = (m_br == 2'd3) || ((div / 4) < int'(m_br));
      is_blank = (d > 0) && m_blz && (upper == 12'h0);
      e_fs     = (m_phase == 0);
      if (is_lit) begin
        e_an   = 3'b111 & ~(3'b001 << d);
        e_seg  = is_blank ? 7'h7F : glyph_tab[upper[3:0]];
        e_dp_n = !m_dp[d];
      end else begin
        e_an = 3'b111; e_seg = 7'h7F; e_dp_n = 1'b1;
      end
      m_phase = (m_phase + 1) % FRAME;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_an", {29'd0, an}, {29'd0, e_an});
    chk("model_seg", {25'd0, seg}, {25'd0, e_seg});
    chk("model_dp_n", {31'd0, dp_n}, {31'd0, e_dp_n});
    chk("model_frame_start", {31'd0, frame_start}, {31'd0, e_fs});
  endtask

  // Called just after a tick: asserts reset between edges and checks outputs before any clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an", {29'd0, an}, 32'h7);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp_n", {31'd0, dp_n}, 32'h1);
    chk("rst_frame_start", {31'd0, frame_start}, 32'h0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  task automatic restart(input logic [11:0] v, input logic [2:0] p, input logic b, input logic [1:0] br);
    enable = 1'b0;
    tick();
    value = v; dp = p; blank_lz = b; brightness = br; enable = 1'b1;
  endtask

  typedef struct {
    logic [11:0] v;
    logic [2:0]  p;
    logic        blz;
    logic [1:0]  br;
    int          digit;
    logic [2:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int cnt, gap;
    vecs[0] = '{12'h3A5, 3'b000, 1'b0, 2'd3, 0, 3'b110, 7'h12, 1'b1};
    vecs[1] = '{12'h3A5, 3'b000, 1'b0, 2'd3, 1, 3'b101, 7'h08, 1'b1};
    vecs[2] = '{12'h3A5, 3'b000, 1'b0, 2'd3, 2, 3'b011, 7'h30, 1'b1};
    vecs[3] = '{12'h005, 3'b100, 1'b1, 2'd3, 2, 3'b011, 7'h7F, 1'b0};
    vecs[4] = '{12'h005, 3'b100, 1'b1, 2'd3, 1, 3'b101, 7'h7F, 1'b1};
    vecs[5] = '{12'h005, 3'b100, 1'b1, 2'd3, 0, 3'b110, 7'h12, 1'b1};
    vecs[6] = '{12'h000, 3'b000, 1'b1, 2'd3, 0, 3'b110, 7'h40, 1'b1};
    vecs[7] = '{12'h3A5, 3'b001, 1'b0, 2'd0, 0, 3'b111, 7'h7F, 1'b1};
    vecs[8] = '{12'h0BD, 3'b000, 1'b1, 2'd3, 1, 3'b101, 7'h03, 1'b1};
    vecs[9] = '{12'h0BD, 3'b010, 1'b1, 2'd3, 2, 3'b011, 7'h7F, 1'b1};

    rst_n = 1'b0; enable = 1'b0; value = '0; dp = '0; blank_lz = 1'b0; brightness = '0;
    model_reset();
    #12;
    chk("init_an", {29'd0, an}, 32'h7);
    chk("init_seg", {25'd0, seg}, 32'h7F);
    chk("init_dp_n", {31'd0, dp_n}, 32'h1);
    chk("init_frame_start", {31'd0, frame_start}, 32'h0);
    rst_n = 1'b1;

    // Directed digit/glyph vectors
    for (int i = 0; i < 10; i++) begin
      restart(vecs[i].v, vecs[i].p, vecs[i].blz, vecs[i].br);
      repeat (DWELL * vecs[i].digit + 1) tick();
      chk($sformatf("vec%0d_an", i), {29'd0, an}, {29'd0, vecs[i].an});
      chk($sformatf("vec%0d_seg", i), {25'd0, seg}, {25'd0, vecs[i].seg});
      chk($sformatf("vec%0d_dp_n", i), {31'd0, dp_n}, {31'd0, vecs[i].dp_n});
    end

    // Brightness duty within one dwell
    for (int b = 0; b < 4; b++) begin
      restart(12'h3A5, 3'b000, 1'b0, 2'(b));
      cnt = 0;
      repeat (DWELL) begin
        tick();
        if (an != 3'b111) cnt++;
      end
      chk($sformatf("duty_b%0d", b), cnt, (b == 3) ? 16 : 4 * b);
    end

    // frame_start period, bounded
    restart(12'h3A5, 3'b000, 1'b0, 2'd3);
    tick();
    chk("first_frame_start", {31'd0, frame_start}, 32'h1);
    gap = 0;
    for (int k = 1; k <= 100 && gap == 0; k++) begin
      tick();
      if (frame_start) gap = k;
    end
    chk("frame_period", gap, FRAME);

    // Value change mid-frame must not tear
    restart(12'h3A5, 3'b000, 1'b0, 2'd3);
    repeat (DWELL + 1) tick();
    value = 12'h000;
    repeat (DWELL) tick();
    chk("tear_digit2_seg", {25'd0, seg}, 32'h30);
    repeat (DWELL) tick();
    chk("tear_next_fs", {31'd0, frame_start}, 32'h1);
    chk("tear_next_seg", {25'd0, seg}, 32'h40);

    // Enable dropped during digit 2, then re-enabled with a new value
    restart(12'h3A5, 3'b000, 1'b0, 2'd3);
    repeat (2 * DWELL + 3) tick();
    chk("en_pre_an", {29'd0, an}, 32'h3);
    enable = 1'b0;
    tick();
    chk("en_off_an", {29'd0, an}, 32'h7);
    chk("en_off_seg", {25'd0, seg}, 32'h7F);
    value = 12'h0E7; enable = 1'b1;
    tick();
    chk("reen_fs", {31'd0, frame_start}, 32'h1);
    chk("reen_an", {29'd0, an}, 32'h6);
    chk("reen_seg", {25'd0, seg}, 32'h78);

    // Asynchronous reset mid-dwell while lit
    restart(12'h3A5, 3'b111, 1'b0, 2'd3);
    repeat (DWELL + 5) tick();
    do_reset();
    tick();
    chk("post_rst_fs", {31'd0, frame_start}, 32'h1);

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) value = 12'($urandom);
      if ($urandom_range(0, 15) == 0) dp = 3'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 15) == 0) brightness = 2'($urandom);
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      tick();
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
